// File: rtl/ext_sbit_receiver.sv
// Receive side of the external HDMI S-bit link: per-bit synchronize, deglitch and stretch,
// then form a programmable coincidence trigger and keep saturating rate counters.
module ext_sbit_receiver #(
    parameter int unsigned NBITS       = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 24
) (
    input  logic                       clock,
    input  logic                       reset_i,
    input  logic [NBITS-1:0]           ext_sbits_i,
    input  logic                       enable_i,
    input  logic [NBITS-1:0]           mask_i,
    input  logic [NBITS-1:0]           invert_i,
    input  logic [3:0]                 min_width_i,
    input  logic [3:0]                 stretch_i,
    input  logic [1:0]                 coinc_mode_i,
    input  logic [2:0]                 coinc_thresh_i,
    input  logic                       cnt_reset_i,
    output logic [NBITS-1:0]           sbits_o,
    output logic                       trigger_o,
    output logic [NBITS*CNT_WIDTH-1:0] bit_cnt_o,
    output logic [CNT_WIDTH-1:0]       trig_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [NBITS-1:0]     sync_q [SYNC_STAGES];
    logic [3:0]           run_q  [NBITS];
    logic [3:0]           run_d  [NBITS];
    logic [3:0]           str_q  [NBITS];
    logic [3:0]           str_d  [NBITS];
    logic [CNT_WIDTH-1:0] bit_cnt_q [NBITS];
    logic [NBITS-1:0]     ev_q, ev_d, sbits_d, cond;
    logic                 coinc_q, coinc_d, coinc_prev_q, trig_d;
    logic [3:0]           w_eff, s_eff;
    logic [2:0]           t_eff;
    int unsigned          n_act, n_unmasked;

    assign w_eff = (min_width_i == 4'd0) ? 4'd1 : min_width_i;
    assign s_eff = (stretch_i == 4'd0) ? 4'd1 : stretch_i;
    assign t_eff = (coinc_thresh_i == 3'd0) ? 3'd1 : coinc_thresh_i;
    assign cond  = (sync_q[SYNC_STAGES-1] ^ invert_i) & ~mask_i & {NBITS{enable_i}};

    always_comb begin
        for (int j = 0; j < NBITS; j++) begin
            run_d[j] = 4'd0;
            if (cond[j]) run_d[j] = (run_q[j] == 4'd15) ? 4'd15 : run_q[j] + 4'd1;
            // One event per run: fires only as the run count passes W-1.
            ev_d[j] = cond[j] && (run_q[j] == w_eff - 4'd1);
            if (ev_q[j])                str_d[j] = s_eff;
            else if (str_q[j] != 4'd0)  str_d[j] = str_q[j] - 4'd1;
            else                        str_d[j] = 4'd0;
            sbits_d[j] = (str_d[j] != 4'd0);
        end
    end

    always_comb begin
        n_act      = 0;
        n_unmasked = 0;
        for (int j = 0; j < NBITS; j++) begin
            n_act      = n_act + 32'(sbits_o[j]);
            n_unmasked = n_unmasked + 32'(!mask_i[j]);
        end
        unique case (coinc_mode_i)
            2'b00:   coinc_d = (n_act >= 1);
            2'b01:   coinc_d = (n_unmasked > 0) && (n_act == n_unmasked);
            2'b10:   coinc_d = (n_act >= 32'(t_eff));
            default: coinc_d = 1'b0;
        endcase
    end

    assign trig_d = coinc_q && !coinc_prev_q;

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int j = 0; j < NBITS; j++) begin
                run_q[j]     <= 4'd0;
                str_q[j]     <= 4'd0;
                bit_cnt_q[j] <= '0;
            end
            ev_q         <= '0;
            sbits_o      <= '0;
            coinc_q      <= 1'b0;
            coinc_prev_q <= 1'b0;
            trigger_o    <= 1'b0;
            trig_cnt_o   <= '0;
        end else begin
            sync_q[0] <= ext_sbits_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int j = 0; j < NBITS; j++) begin
                run_q[j] <= run_d[j];
                str_q[j] <= str_d[j];
                if (cnt_reset_i)                               bit_cnt_q[j] <= '0;
                else if (ev_q[j] && bit_cnt_q[j] != CntMax)   bit_cnt_q[j] <= bit_cnt_q[j] + 1'b1;
            end
            ev_q         <= ev_d;
            sbits_o      <= sbits_d;
            coinc_q      <= coinc_d;
            coinc_prev_q <= coinc_q;
            trigger_o    <= trig_d;
            if (cnt_reset_i)                       trig_cnt_o <= '0;
            else if (trig_d && trig_cnt_o != CntMax) trig_cnt_o <= trig_cnt_o + 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < NBITS; j++) bit_cnt_o[j*CNT_WIDTH +: CNT_WIDTH] = bit_cnt_q[j];
    end

endmodule

// File: doc/ext_sbit_receiver.md
Name: ext_sbit_receiver

Overview:
Receive side of the 6-bit external HDMI S-bit link: samples six asynchronous trigger bits arriving from another OptoHybrid or external trigger source. Each bit is synchronized, deglitched by minimum width, and stretched per bit. The block then forms a programmable coincidence trigger pulse and keeps saturating per-bit and trigger counters for slow-control readout. It sits between the HDMI input pins and the trigger/control logic.

Parameters:
NBITS, 6, number of external S-bit lines
SYNC_STAGES, 2, synchronizer flops per bit (minimum 2)
CNT_WIDTH, 24, width of every rate counter

Ports:
clock  input  1  fabric clock; all logic in this single domain
reset_i  input  1  asynchronous, active-high reset; clears all flops
ext_sbits_i  input  NBITS  asynchronous HDMI S-bit inputs
enable_i  input  1  global receive enable
mask_i  input  NBITS  1 = ignore bit
invert_i  input  NBITS  1 = bit is active-low on the cable
min_width_i  input  4  required consecutive high cycles W (0 treated as 1)
stretch_i  input  4  output pulse length S in cycles (0 treated as 1)
coinc_mode_i  input  2  00 OR, 01 AND of unmasked, 10 majority, 11 off
coinc_thresh_i  input  3  majority threshold T (0 treated as 1)
cnt_reset_i  input  1  synchronous clear of all counters
sbits_o  output  NBITS  qualified, stretched S-bits
trigger_o  output  1  one-cycle coincidence trigger pulse
bit_cnt_o  output  NBITS*CNT_WIDTH  per-bit event counters; bit j occupies [j*CNT_WIDTH +: CNT_WIDTH]
trig_cnt_o  output  CNT_WIDTH  trigger_o counter

Behaviour:
- Reset: asynchronous, active-high. Synchronizers, run counters, stretch counters, coincidence register, sbits_o, trigger_o and all counters are 0 while reset_i is high. Normal operation resumes on the first clock edge after deassertion. A reset mid-pulse truncates the pulse.
- Conditioning: c[j] = sync[j] XOR invert_i[j], AND NOT mask_i[j], AND enable_i. All config inputs are quasi-static and are used directly, with no registering.
- Deglitch: per-bit 4-bit run counter.
  - Increments (saturating at 15) while c[j]=1; clears to 0 when c[j]=0.
  - Registered event ev[j] fires for one cycle when c[j]=1 and run==W-1, giving exactly one event per high run.
  - Runs shorter than W produce nothing. A change to W mid-run applies from the next edge.
- Stretch: per-bit 4-bit down counter.
  - ev[j] loads S. An ev[j] while the counter is nonzero reloads S, extending the pulse.
  - Otherwise the counter decrements to 0.
  - sbits_o[j] is registered, high while the counter is nonzero.
  - Clearing enable_i or a mask bit does not truncate an active stretch.
- Latency: cycle 0 is the first edge at which the first sync flop captures an active level.
  - ev high after edge SYNC_STAGES-1+W.
  - sbits_o rises after edge SYNC_STAGES+W and stays high exactly S cycles (no retrigger).
  - Default config (SYNC_STAGES=2, W=1, S=1): sbits_o high after edge 3.
- Coincidence: computed on sbits_o; let n = popcount(sbits_o) and u = popcount(NOT mask_i).
  - Mode 00: n>=1.
  - Mode 01: u>0 and n==u.
  - Mode 10: n>=T.
  - Mode 11: 0.
  - The result is registered as coinc, one edge after sbits_o.
- Trigger: trigger_o is registered, asserting for one cycle at the edge after coinc goes 0->1 (2 edges after the sbits_o rise). It does not reassert while coinc stays high.
- Counters:
  - bit_cnt[j] increments at the edge sbits_o[j] rises from an event, i.e. once per ev[j], retriggers included.
  - trig_cnt increments at the edge trigger_o asserts.
  - All counters saturate at 2^CNT_WIDTH-1 with no wrap.
  - cnt_reset_i clears all counters and has priority over a simultaneous increment.

Test Plan:
- Defaults (W=1, S=1, mode 00, no mask/invert); bit 2 driven high for 5 cycles -> sbits_o[2] high exactly 1 cycle, 3 edges after capture; trigger_o 1 cycle, 2 edges later; bit_cnt[2]=1, trig_cnt=1.
- W=4, S=3; 3-cycle glitch on bit 0, then a 10-cycle pulse -> no output for the glitch; one 3-cycle sbits_o[0] pulse; bit_cnt[0]=1.
- Mode 01, mask_i=6'b111100; bits 0 and 1 pulsed 2 cycles apart with S=4 -> one trigger_o when the stretches overlap; with mask_i=6'b111111 -> no trigger.
- Mode 10, T=3; bits 0,1,2 active together -> trigger_o=1; only 0,1 active -> 0. Mode 11 with all six bits active -> trigger_o stays 0.
- invert_i=6'h3F with inputs idle-high -> no events; drop bit 5 low -> event on bit 5. enable_i=0 -> no events.
- Preload bit_cnt[1] near max with CNT_WIDTH=4 -> holds at 15 after extra events. cnt_reset_i on the same cycle as an increment -> reads 0. reset_i asserted mid-stretch -> sbits_o=0 immediately, without waiting for a clock edge.
